// File: rtl/gerenciador_swap.sv
// gerenciador_swap
// Request manager in front of the three-register bus swap unit.
// Queues swap requests as a pending count, issues one-cycle start pulses (w),
// waits for done from the swap unit, snoops the shared bus on completion,
// counts completed swaps and latches a sticky timeout error.

module gerenciador_swap #(
    parameter int MAX_PEND = 4,   // legal 1..7
    parameter int TIMEOUT  = 15   // legal 1..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    output logic       aceito,
    output logic       cheio,
    output logic [2:0] pendentes,
    output logic       w,
    input  logic       done,
    input  logic [5:0] barramento,
    output logic [5:0] ultimo_valor,
    output logic [7:0] trocas,
    output logic       ocupado,
    output logic       erro
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        PULSO_W = 2'd1,
        ESPERA  = 2'd2,
        ERRO    = 2'd3
    } estado_t;

    // Queue limit and the timer value seen in the last allowed wait cycle
    // (the timer starts at 0 in the first wait cycle).
    localparam logic [2:0] MAX_PEND_C     = 3'(MAX_PEND);
    localparam logic [3:0] ULTIMO_CICLO_C = 4'(TIMEOUT - 1);

    estado_t    estado_r;
    estado_t    estado_s;
    logic [3:0] timer_r;
    logic [3:0] timer_s;
    logic [2:0] pend_r;
    logic [2:0] pend_s;
    logic [7:0] trocas_r;
    logic [7:0] trocas_s;
    logic [5:0] ult_r;
    logic [5:0] ult_s;
    logic       erro_r;
    logic       erro_s;
    logic       w_r;
    logic       cheio_r;
    logic       ocupado_r;

    logic       aceito_s;
    logic       conclui_s;

    // Pure helper: next pending count from accept/complete events.
    // Accept and completion in the same cycle cancel out.
    function automatic logic [2:0] proximo_pendentes(
        input logic [2:0] atual,
        input logic       entra,
        input logic       sai
    );
        logic [2:0] res;
        case ({entra, sai})
            2'b10:   res = atual + 3'd1;
            2'b01:   res = atual - 3'd1;
            default: res = atual;
        endcase
        return res;
    endfunction

    // Request acceptance: room in the queue and not locked in the error state.
    always_comb begin
        aceito_s = 1'b0;
        if (req && (pend_r < MAX_PEND_C) && (estado_r != ERRO)) begin
            aceito_s = 1'b1;
        end else begin
            aceito_s = 1'b0;
        end
    end

    // Next-state logic, wait timer and completion/timeout detection.
    always_comb begin
        estado_s  = estado_r;
        timer_s   = timer_r;
        erro_s    = erro_r;
        conclui_s = 1'b0;
        case (estado_r)
            OCIOSO: begin
                if (pend_r != 3'd0) begin
                    estado_s = PULSO_W;
                end else begin
                    estado_s = OCIOSO;
                end
            end
            PULSO_W: begin
                // Single start-pulse cycle; timer restarts for the wait.
                estado_s = ESPERA;
                timer_s  = 4'd0;
            end
            ESPERA: begin
                // done wins even in the last allowed wait cycle.
                if (done) begin
                    estado_s  = OCIOSO;
                    conclui_s = 1'b1;
                end else if (timer_r == ULTIMO_CICLO_C) begin
                    estado_s = ERRO;
                    erro_s   = 1'b1;
                end else begin
                    timer_s = timer_r + 4'd1;
                end
            end
            ERRO: begin
                // Terminal until reset; done is ignored here.
                estado_s = ERRO;
            end
            default: begin
                estado_s = OCIOSO;
            end
        endcase
    end

    // Counter and snoop updates driven by accept/completion events.
    always_comb begin
        pend_s   = proximo_pendentes(pend_r, aceito_s, conclui_s);
        trocas_s = trocas_r;
        ult_s    = ult_r;
        if (conclui_s) begin
            trocas_s = trocas_r + 8'd1;
            ult_s    = barramento;
        end else begin
            trocas_s = trocas_r;
            ult_s    = ult_r;
        end
    end

    // State register and wait timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_r <= OCIOSO;
            timer_r  <= 4'd0;
        end else begin
            estado_r <= estado_s;
            timer_r  <= timer_s;
        end
    end

    // Pending count, completed-swap counter, bus snoop and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_r   <= 3'd0;
            trocas_r <= 8'd0;
            ult_r    <= 6'd0;
            erro_r   <= 1'b0;
        end else begin
            pend_r   <= pend_s;
            trocas_r <= trocas_s;
            ult_r    <= ult_s;
            erro_r   <= erro_s;
        end
    end

    // Registered status flags; w is high exactly while the state is PULSO_W,
    // so it is glitch-free and never lasts two cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_r       <= 1'b0;
            cheio_r   <= 1'b0;
            ocupado_r <= 1'b0;
        end else begin
            w_r       <= (estado_s == PULSO_W);
            cheio_r   <= (pend_s == MAX_PEND_C);
            ocupado_r <= (estado_s != OCIOSO) || (pend_s != 3'd0);
        end
    end

    assign aceito       = aceito_s;
    assign cheio        = cheio_r;
    assign pendentes    = pend_r;
    assign w            = w_r;
    assign ultimo_valor = ult_r;
    assign trocas       = trocas_r;
    assign ocupado      = ocupado_r;
    assign erro         = erro_r;

endmodule

// File: doc/gerenciador_swap.md
# gerenciador_swap

Request manager sitting directly upstream of the three-register bus swap unit. Accepts swap requests from the surrounding logic, queues them as a pending count, issues one-cycle `w` start pulses to the swap unit, and waits for its `done` before issuing the next. While a swap is in flight it snoops the shared 6-bit `barramento`. It also keeps a completed-swap counter and a sticky timeout error.

## Interface
- `MAX_PEND`, default 4: maximum queued requests, legal range 1..7.
- `TIMEOUT`, default 15: maximum cycles spent waiting for `done`, legal range 1..15.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `req`  input  1  swap request, sampled each cycle.
- `aceito`  output  1  combinational; high in the same cycle a `req` is accepted.
- `cheio`  output  1  high when `pendentes == MAX_PEND`.
- `pendentes`  output  3  number of queued requests not yet completed.
- `w`  output  1  start pulse to the swap unit.
- `done`  input  1  completion pulse from the swap unit.
- `barramento`  input  6  snoop-only view of the shared bus; this block never drives it.
- `ultimo_valor`  output  6  bus value sampled in the cycle `done` was accepted.
- `trocas`  output  8  count of completed swaps.
- `ocupado`  output  1  high when state ≠ OCIOSO or `pendentes ≠ 0`.
- `erro`  output  1  sticky timeout flag.

## Operation
- **Reset values:** state OCIOSO; `pendentes` = 0; `trocas` = 0; `ultimo_valor` = 0; `w` = 0; `erro` = 0; wait timer = 0.
- **States:**
  - OCIOSO: if `pendentes > 0`, go to PULSO_W.
  - PULSO_W: `w` = 1 for exactly this one cycle; clear the timer; next state is always ESPERA.
  - ESPERA: the timer counts ESPERA cycles, starting at 0 in the first ESPERA cycle.
    - On `done` = 1: go to OCIOSO; decrement `pendentes`; increment `trocas` (wraps 255 → 0); load `ultimo_valor` from `barramento`.
    - Otherwise, in the `TIMEOUT`-th ESPERA cycle: go to ERRO and set `erro`.
    - `done` in that final cycle counts as success.
  - ERRO: terminal until `reset`. `w` = 0, `aceito` = 0, `pendentes` frozen, `done` ignored.
- **Request acceptance:** `aceito = req && pendentes < MAX_PEND && state ≠ ERRO`. An accepted request increments `pendentes` at the edge. An unaccepted `req` is dropped with no side effects; the requester must hold `req` and retry.
- **Simultaneous accept and completion** in the same cycle: `pendentes` is unchanged and `trocas` still increments.
- **`done` outside ESPERA** (OCIOSO, PULSO_W): ignored; no counter changes.
- **`w`** is a decode of the registered state only, so it is glitch-free and never high in two consecutive cycles.
- **Swap spacing:** back-to-back queued swaps are separated by one OCIOSO cycle. The minimum period is 3 cycles per swap when `done` arrives in the first ESPERA cycle.

## Timing
- **Request to `w`:** `req` accepted in cycle N with the block idle and empty gives `pendentes` = 1 from N+1, state PULSO_W in N+2, and `w` = 1 in N+2.
- **`done` to outputs:** `done` in ESPERA cycle M updates `trocas`, `pendentes` and `ultimo_valor`, visible from M+1.
- **Timeout:** with no `done`, ERRO is entered at the end of ESPERA cycle `TIMEOUT` counted from the first ESPERA cycle. `erro` = 1 from the following cycle.
- **Reset mid-operation** (any state, including with `w` high): all outputs take their reset values asynchronously. The in-flight swap is abandoned, and a later `done` is ignored because the state is OCIOSO.

## Test plan
- **Single swap:** one `req` pulse, `done` pulsed 2 cycles after `w`, bus held at 6'h2A → `w` high exactly once, 2 cycles after `aceito`; then `trocas` = 1, `ultimo_valor` = 6'h2A, `pendentes` = 0, `ocupado` = 0.
- **Queue fill and overflow:** `req` held high for 6 cycles, `done` withheld → `aceito` high for 4 cycles; `pendentes` = 4; `cheio` = 1; 5th and 6th requests dropped; `pendentes` does not exceed 4.
- **Simultaneous events:** `pendentes` = 2 in ESPERA, `req` and `done` in the same cycle → `pendentes` stays 2, `trocas` +1, next `w` follows one OCIOSO cycle later.
- **Timeout:** `TIMEOUT` = 15, `done` never asserted → ERRO after the 15th ESPERA cycle, `erro` = 1. Later `req` gives `aceito` = 0; later `done` leaves `trocas` unchanged.
- **Reset mid-swap:** `reset` pulsed during ESPERA with `pendentes` = 3 → all outputs 0 immediately. A `done` right after reset is ignored and `trocas` stays 0.
- **Counter wrap:** 256 completed swaps → `trocas` reads 255, then 0; `erro` stays 0.
